// File: rtl/rat_io_pkg.sv
// Shared constants for the RAT MCU port bus peripherals.
//   Port IDs   : addresses decoded by the input/output muxes of the MCU wrapper.
//   STAT_*_BIT : bit positions inside the event port status byte.
//   CTRL_*_BIT : command bit positions in writes to the event port control ID.
package rat_io_pkg;

  // Existing wrapper peripherals
  localparam logic [7:0] SWITCHES_ID = 8'h20;
  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] SEVSEG_ID   = 8'h81;

  // Event input port
  localparam logic [7:0] DATA_ID   = 8'h30;
  localparam logic [7:0] STATUS_ID = 8'h31;
  localparam logic [7:0] CTRL_ID   = 8'h32;

  // Status byte layout: {OVF, EMPTY, FULL, 1'b0, count[3:0]}
  localparam int unsigned STAT_OVF_BIT   = 7;
  localparam int unsigned STAT_EMPTY_BIT = 6;
  localparam int unsigned STAT_FULL_BIT  = 5;

  // Control write bits
  localparam int unsigned CTRL_POP_BIT     = 0;
  localparam int unsigned CTRL_CLR_OVF_BIT = 1;
  localparam int unsigned CTRL_FLUSH_BIT   = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a previous-value register, producing a
// one-cycle rising-edge vector per bit.
//   CLK   : destination clock
//   RESET : asynchronous active-high reset, clears all stages
//   d     : asynchronous input lines
//   rise  : per-bit rising edge of the synchronized lines (combinational)
module sync_edge_detect #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/event_in_port.sv
// Event input port on the RAT MCU port bus. Synchronizes 8 external lines,
// queues every non-zero rising-edge vector in a small FIFO and pulses INT for
// each queued event. The MCU reads the FIFO head and a status byte, and
// writes pop / clear-overflow / flush commands.
//   CLK, RESET : clock, asynchronous active-high reset
//   IN_SIG     : asynchronous external lines
//   PORT_ID    : MCU port address
//   OUT_PORT   : MCU write data (bit0 pop, bit1 clear OVF, bit2 flush)
//   IO_STRB    : MCU write strobe
//   IN_PORT    : combinational read data (head entry or status)
//   IN_VALID   : PORT_ID hits DATA_ID or STATUS_ID; select for the wrapper mux
//   INT        : interrupt pulse, INT_WIDTH cycles per accepted event
module event_in_port
  import rat_io_pkg::*;
#(
  parameter logic [7:0]  DATA_ID   = rat_io_pkg::DATA_ID,
  parameter logic [7:0]  STATUS_ID = rat_io_pkg::STATUS_ID,
  parameter logic [7:0]  CTRL_ID   = rat_io_pkg::CTRL_ID,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INT_WIDTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN_SIG,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       IN_VALID,
  output logic       INT
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [3:0]      IntLoad = 4'(INT_WIDTH);

  logic [7:0]      rise;
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;
  logic [3:0]      int_cnt_q;

  logic ctrl_wr;
  logic pop_req;
  logic clr_ovf;
  logic flush;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic overflow;
  logic [7:0] status;
  logic unused_out_port;

  sync_edge_detect #(
    .WIDTH(8)
  ) u_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .d    (IN_SIG),
    .rise (rise)
  );

  assign unused_out_port = ^OUT_PORT[7:3];

  assign ctrl_wr = IO_STRB && (PORT_ID == CTRL_ID);
  assign pop_req = ctrl_wr && OUT_PORT[CTRL_POP_BIT];
  assign clr_ovf = ctrl_wr && OUT_PORT[CTRL_CLR_OVF_BIT];
  assign flush   = ctrl_wr && OUT_PORT[CTRL_FLUSH_BIT];

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // Flush discards everything this cycle, including an incoming edge vector.
  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop      = pop_req && !empty && !flush;
  assign push     = (rise != 8'h00) && !flush && (!full || pop);
  assign overflow = (rise != 8'h00) && !flush && full && !pop;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      int_cnt_q <= '0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
          count_q <= count_q + CntW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CntW'(1);
        end
      end

      // A new overflow beats a same-cycle clear so no drop goes unreported.
      if (overflow) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end

      if (push) begin
        int_cnt_q <= IntLoad;
      end else if (int_cnt_q != 4'd0) begin
        int_cnt_q <= int_cnt_q - 4'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= rise;
  end

  assign INT = (int_cnt_q != 4'd0);

  always_comb begin
    status                 = 8'h00;
    status[STAT_OVF_BIT]   = ovf_q;
    status[STAT_EMPTY_BIT] = empty;
    status[STAT_FULL_BIT]  = full;
    status[3:0]            = 4'(count_q);
  end

  always_comb begin
    IN_PORT  = 8'h00;
    IN_VALID = 1'b0;
    if (PORT_ID == DATA_ID) begin
      IN_VALID = 1'b1;
      IN_PORT  = empty ? 8'h00 : mem_q[rd_ptr_q];
    end else if (PORT_ID == STATUS_ID) begin
      IN_VALID = 1'b1;
      IN_PORT  = status;
    end
  end

endmodule

// File: tb/tb_event_in_port.sv
module tb_event_in_port;
  import rat_io_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned INT_WIDTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN_SIG;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       IN_VALID;
  logic       INT;

  event_in_port #(
    .DATA_ID  (DATA_ID),
    .STATUS_ID(STATUS_ID),
    .CTRL_ID  (CTRL_ID),
    .DEPTH    (DEPTH),
    .INT_WIDTH(INT_WIDTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IN_SIG  (IN_SIG),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .IO_STRB (IO_STRB),
    .IN_PORT (IN_PORT),
    .IN_VALID(IN_VALID),
    .INT     (INT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    string      tag;
  } rd_exp_t;

  typedef struct {
    int   cyc;
    logic v;
  } int_exp_t;

  rd_exp_t  rd_q[$];
  int_exp_t int_q[$];

  int cyc_n = 0;
  int total = 0;
  int bad   = 0;

  // Reference model: event queue, sticky overflow, remaining INT cycles and
  // the line values sampled at the last three clock edges (newest first).
  logic [7:0] m_fifo[$];
  logic       m_ovf;
  int         m_int;
  logic [7:0] m_hist[$];
  logic [7:0] cur_sig;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic model_reset();
    m_fifo.delete();
    m_ovf  = 1'b0;
    m_int  = 0;
    m_hist = '{8'h00, 8'h00, 8'h00};
  endtask

  // A line change sampled at edge k-2 that was not present at edge k-3 is an
  // event at edge k.
  task automatic model_edge();
    logic [7:0] rise;
    logic       wr;
    logic       ovf_set;
    if (RESET) return;
    rise   = m_hist[1] & ~m_hist[2];
    m_hist = '{IN_SIG, m_hist[0], m_hist[1]};
    wr      = IO_STRB && (PORT_ID == CTRL_ID);
    ovf_set = 1'b0;
    if (m_int > 0) m_int--;
    if (wr && OUT_PORT[2]) begin
      m_fifo.delete();
    end else begin
      if (wr && OUT_PORT[0] && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (rise != 8'h00) begin
        if (m_fifo.size() < int'(DEPTH)) begin
          m_fifo.push_back(rise);
          m_int = int'(INT_WIDTH);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
    if (wr && OUT_PORT[1]) m_ovf = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] pid);
    int n;
    n = m_fifo.size();
    if (pid == DATA_ID) return (n > 0) ? m_fifo[0] : 8'h00;
    return {m_ovf, n == 0, n == int'(DEPTH), 1'b0, 4'(n)};
  endfunction

  // One bus cycle, entered just after a rising edge: drive inputs, queue the
  // expected outputs for this cycle, then advance the model at the next edge.
  task automatic cyc(input logic rst, input logic [7:0] sig, input logic [7:0] pid,
                     input logic [7:0] od, input logic strb, input logic use_k,
                     input logic [7:0] k, input string tag);
    rd_exp_t  r;
    int_exp_t e;
    RESET    = rst;
    IN_SIG   = sig;
    PORT_ID  = pid;
    OUT_PORT = od;
    IO_STRB  = strb;
    if (rst) model_reset();
    if (pid == DATA_ID || pid == STATUS_ID) begin
      r.cyc  = cyc_n;
      r.data = use_k ? k : model_read(pid);
      r.tag  = use_k ? tag : ((pid == DATA_ID) ? "data" : "status");
      rd_q.push_back(r);
    end
    e.cyc = cyc_n;
    e.v   = (m_int != 0);
    int_q.push_back(e);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, cur_sig, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, "");
  endtask

  task automatic rd(input logic [7:0] pid, input logic [7:0] k, input string tag);
    cyc(1'b0, cur_sig, pid, 8'h00, 1'b0, 1'b1, k, tag);
  endtask

  task automatic wr(input logic [7:0] od);
    cyc(1'b0, cur_sig, CTRL_ID, od, 1'b1, 1'b0, 8'h00, "");
  endtask

  task automatic rst_cyc(input logic [7:0] pid, input logic [7:0] k, input string tag);
    cur_sig = 8'h00;
    cyc(1'b1, cur_sig, pid, 8'h00, 1'b0, 1'b1, k, tag);
  endtask

  // Raise one additional line per cycle, n times, starting from bit 0.
  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      cur_sig = (cur_sig << 1) | 8'h01;
      idle(1);
    end
  endtask

  always @(negedge CLK) begin : mon
    rd_exp_t  r;
    int_exp_t e;
    if (IN_VALID) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL stray_read: in_valid=1 in_port=%02h at cycle %0d, required no read",
                 IN_PORT, cyc_n);
      end else begin
        r = rd_q.pop_front();
        if (r.cyc != cyc_n || IN_PORT !== r.data) begin
          bad++;
          $display("FAIL %s: in_port=%02h at cycle %0d, required %02h at cycle %0d",
                   r.tag, IN_PORT, cyc_n, r.data, r.cyc);
        end
      end
    end
    if (int_q.size() != 0) begin
      e = int_q.pop_front();
      total++;
      if (e.cyc != cyc_n || INT !== e.v) begin
        bad++;
        $display("FAIL int: int=%0b at cycle %0d, required %0b at cycle %0d",
                 INT, cyc_n, e.v, e.cyc);
      end
    end
  end

  initial begin
    logic [7:0] pid;
    logic [7:0] od;
    logic       strb;
    logic       rst;
    int         r;

    RESET    = 1'b1;
    IN_SIG   = 8'h00;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    cur_sig  = 8'h00;
    model_reset();
    @(posedge CLK);
    #1;

    // Reset state
    rst_cyc(STATUS_ID, 8'h40, "rst_status");
    rst_cyc(DATA_ID, 8'h00, "rst_data");
    idle(6);

    // Single event, then pops
    cur_sig = 8'h05;
    idle(3);
    rd(STATUS_ID, 8'h01, "one_status");
    rd(DATA_ID, 8'h05, "one_data");
    wr(8'h01);
    rd(STATUS_ID, 8'h40, "pop_status");
    rd(DATA_ID, 8'h00, "pop_data");
    wr(8'h01);
    rd(STATUS_ID, 8'h40, "pop_empty_status");
    idle(4);

    // Five single-bit rises overflow a 4-deep queue
    cur_sig = 8'h00;
    idle(3);
    rises(5);
    idle(2);
    rd(STATUS_ID, 8'hA4, "ovf_status");
    rd(DATA_ID, 8'h01, "drain0");
    wr(8'h01);
    rd(DATA_ID, 8'h02, "drain1");
    wr(8'h01);
    rd(DATA_ID, 8'h04, "drain2");
    wr(8'h01);
    rd(DATA_ID, 8'h08, "drain3");
    wr(8'h01);
    rd(STATUS_ID, 8'hC0, "ovf_empty_status");
    wr(8'h02);
    rd(STATUS_ID, 8'h40, "ovf_clr_status");

    // Push and pop on the same edge while full
    cur_sig = 8'h00;
    idle(3);
    rises(4);
    idle(2);
    rd(STATUS_ID, 8'h24, "full_status");
    rd(DATA_ID, 8'h01, "full_head");
    cur_sig = 8'h1F;
    idle(2);
    wr(8'h01);
    rd(STATUS_ID, 8'h24, "pushpop_status");
    rd(DATA_ID, 8'h02, "pushpop_head");
    wr(8'h01);
    rd(DATA_ID, 8'h04, "pushpop_1");
    wr(8'h01);
    rd(DATA_ID, 8'h08, "pushpop_2");
    wr(8'h01);
    rd(DATA_ID, 8'h10, "pushpop_tail");
    wr(8'h01);
    rd(STATUS_ID, 8'h40, "pushpop_empty");

    // Flush + clear OVF on the same edge as a push
    cur_sig = 8'h00;
    idle(3);
    cur_sig = 8'h20;
    idle(3);
    rd(DATA_ID, 8'h20, "preflush_data");
    cur_sig = 8'h60;
    idle(2);
    wr(8'h06);
    rd(STATUS_ID, 8'h40, "flush_status");
    rd(DATA_ID, 8'h00, "flush_data");
    idle(2);
    rd(STATUS_ID, 8'h40, "flush_late_status");

    // Asynchronous reset in the middle of an INT pulse
    cur_sig = 8'h00;
    idle(3);
    rises(3);
    idle(2);
    rd(STATUS_ID, 8'h03, "three_status");
    rst_cyc(STATUS_ID, 8'h40, "rst_mid_status");
    rst_cyc(DATA_ID, 8'h00, "rst_mid_data");
    idle(3);
    rd(STATUS_ID, 8'h40, "post_rst_status");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) cur_sig = cur_sig ^ (8'h01 << $urandom_range(0, 7));
      else if (r == 3) cur_sig = 8'($urandom);
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2: pid = DATA_ID;
        3, 4:    pid = STATUS_ID;
        5:       pid = CTRL_ID;
        6:       pid = 8'($urandom);
        default: pid = 8'h00;
      endcase
      od   = {5'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom)};
      strb = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      if (rst) cur_sig = 8'h00;
      cyc(rst, cur_sig, pid, od, strb, 1'b0, 8'h00, "");
    end

    PORT_ID = 8'h00;
    IO_STRB = 1'b0;
    @(negedge CLK);
    #1;
    total++;
    if (rd_q.size() != 0) begin
      bad++;
      $display("FAIL missed_reads: pending=%0d, required 0", rd_q.size());
    end
    total++;
    if (int_q.size() != 0) begin
      bad++;
      $display("FAIL missed_int: pending=%0d, required 0", int_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_in_port.md
Name: event_in_port

Overview:
- Input-side responder on the RAT MCU port bus. The MCU is the initiator: it drives PORT_ID, OUT_PORT and IO_STRB, and samples IN_PORT.
- Block synchronizes 8 external lines (buttons/switches), detects rising edges and queues each non-zero edge vector in a small FIFO.
- Raises an interrupt pulse toward the MCU on each queued event.
- Serves reads of data and status through the wrapper's input mux; accepts pop/clear/flush commands through output-port writes.

Parameters:
- DATA_ID, 8'h30, port ID returning the FIFO head.
- STATUS_ID, 8'h31, port ID returning the status byte.
- CTRL_ID, 8'h32, port ID for write commands.
- DEPTH, 4, FIFO entries; power of two, 2..8.
- INT_WIDTH, 4, INT pulse length in clock cycles, 1..15.

Ports:
- CLK, input, 1, system clock (MCU clock domain).
- RESET, input, 1, asynchronous active-high reset.
- IN_SIG, input, 8, asynchronous external lines.
- PORT_ID, input, 8, MCU port address.
- OUT_PORT, input, 8, MCU write data.
- IO_STRB, input, 1, MCU write strobe, 1 cycle.
- IN_PORT, output, 8, read data; combinational.
- IN_VALID, output, 1, high when PORT_ID equals DATA_ID or STATUS_ID; the wrapper mux uses it as a select.
- INT, output, 1, interrupt request pulse.

Behaviour:
- Reset (async, RESET=1):
  - Clears sync flops, prev register, FIFO pointers and count, OVF, and INT counter.
  - INT=0. IN_PORT=00 unless PORT_ID matches, in which case it returns the reset-state value.
  - Clean restart on deassertion; any event in flight is lost.
- Synchronizer: 2 flops per bit, then a prev register.
  - rise = sync2 & ~prev.
  - push = (rise != 0).
- Latency: IN_SIG rising before edge t → sync1 at t, sync2 at t+1, push at edge t+2. Entry readable and INT high after t+2.
- FIFO: DEPTH x 8, read/write pointers, count width clog2(DEPTH)+1.
  - Push when full: data dropped, OVF set (sticky).
  - Push and pop in the same cycle when full: both occur, count unchanged, no OVF.
  - Push and pop in the same cycle when empty: push occurs, pop ignored.
  - Pointers wrap modulo DEPTH.
- Reads (combinational, no side effects):
  - PORT_ID==DATA_ID: IN_PORT = head entry, or 00 when empty.
  - PORT_ID==STATUS_ID: IN_PORT = {OVF, EMPTY, FULL, 1'b0, count[3:0]}.
  - Otherwise IN_PORT=00, IN_VALID=0.
- Writes: act on the clock edge where IO_STRB=1 and PORT_ID==CTRL_ID.
  - OUT_PORT bit0: pop; ignored if empty.
  - OUT_PORT bit1: clear OVF.
  - OUT_PORT bit2: flush (pointers=0, count=0).
  - Flush overrides pop and any same-cycle push; the pushed vector is discarded and OVF is not set.
  - Clear OVF and a same-cycle overflow: set wins, OVF=1.
  - Writes to other IDs are ignored.
- INT:
  - Counter loads INT_WIDTH on each accepted push; INT=1 while counter≠0, decrementing once per cycle.
  - A push while the counter is running reloads it, extending the pulse.
  - Dropped pushes do not trigger INT.
- Multiple bits rising together form one entry; later rises of other bits form separate entries.

Decomposition:
- Shared package rat_io_pkg:
  - Port ID constants (DATA_ID, STATUS_ID, CTRL_ID alongside the existing SWITCHES/LEDS/SEVSEG IDs).
  - STATUS bit positions: OVF=7, EMPTY=6, FULL=5.
  - CTRL bit positions: POP=0, CLR_OVF=1, FLUSH=2.
- One sub-module, sync_edge_detect: parameter WIDTH; ports CLK, RESET, d, rise. Contains the 2-flop synchronizer and prev register.
- FIFO, port decode and INT counter stay in event_in_port.

Test Plan:
- Reset, then raise IN_SIG=8'h05 at cycle 10:
  - Push at cycle 12, INT high cycles 12-15.
  - PORT_ID=31 reads 8'h01; PORT_ID=30 reads 8'h05.
- Pop: write CTRL_ID OUT_PORT=01 with IO_STRB:
  - Next cycle STATUS reads 8'h40; DATA reads 00.
  - A second pop changes nothing.
- Five distinct single-bit rises (01,02,04,08,10) with no pops:
  - STATUS=8'hA4 (OVF, FULL, count 4); only 4 INT reloads occur.
  - Reads then pops return 01,02,04,08.
- Full FIFO, push and pop in the same cycle: count stays 4, OVF stays 0, head advances, new entry lands at the tail.
- Flush plus clear-OVF write (OUT_PORT=06) in the same cycle as a push: STATUS reads 8'h40 and the pushed vector is absent.
- Assert RESET asynchronously mid-INT pulse with 3 entries queued: INT drops immediately; STATUS reads 8'h40 once PORT_ID=31.
